// File: rtl/dir_cmd_queue.sv
// -----------------------------------------------------------------------------
// dir_cmd_queue
//
// Turns four raw direction push-buttons into a queued stream of snake heading
// commands for game_logic. Each button is synchronised and debounced. A press
// event is a debounced rising edge. One event per cycle is arbitrated
// (UP > DOWN > LEFT > RIGHT) and filtered against the reference heading: a
// repeat of the heading or a 180-degree reversal is dropped. Accepted commands
// go into a small FIFO. One command is popped per game update tick, so two
// quick presses between ticks are both honoured, in order.
//
// Parameters
//   DEBOUNCE_CYCLES  stable sync-level cycles needed before a button level flips
//   FIFO_DEPTH       command queue entries (power of two, >= 2)
//
// Ports
//   clk          in   system clock, single domain
//   rst          in   synchronous, active-high reset
//   left/right/up/down
//                in   raw buttons, active-high, asynchronous to clk
//   upd_tick     in   one-cycle strobe, once per game update step
//   direction    out  current heading: 00=LEFT 01=RIGHT 10=UP 11=DOWN
//   dir_changed  out  one-cycle pulse in the cycle direction takes a new value
//   q_count      out  number of commands currently queued
// -----------------------------------------------------------------------------
module dir_cmd_queue #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          left,
    input  logic                          right,
    input  logic                          up,
    input  logic                          down,
    input  logic                          upd_tick,
    output logic [1:0]                    direction,
    output logic                          dir_changed,
    output logic [$clog2(FIFO_DEPTH):0]   q_count
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0]   DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

    // The heading encoding doubles as the button index, so press vectors
    // and the queue share one numbering.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    // ---------------- button conditioning ----------------
    logic [3:0] btn_raw;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] db_q, db_d;
    logic [3:0] press_q, press_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    assign btn_raw = {down, up, right, left};

    // NOTE: every variable gets its default first, so no path can leave one
    // unassigned and no latch is inferred.
    always_comb begin
        // First synchroniser stage is a bare flop; nothing combinational
        // sits in front of it.
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // Registered rising edge of the debounced level: one-cycle press event.
        press_d = db_d & ~db_q;
    end

    // ---------------- arbitration + queue ----------------
    dir_e            mem_q [FIFO_DEPTH];
    dir_e            mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   last_ptr;
    logic [CNTW-1:0] count_q, count_d;
    dir_e            dir_q, dir_d;
    logic            chg_q, chg_d;

    logic            cand_valid;
    dir_e            cand;
    dir_e            ref_dir;
    dir_e            opp_dir;
    logic            pop;
    logic            push;
    logic            full_after_pop;

    always_comb begin
        // Press vector bits: [3]=DOWN [2]=UP [1]=RIGHT [0]=LEFT.
        // Lower-priority simultaneous presses are simply discarded.
        cand_valid = |press_q;
        if (press_q[2]) begin
            cand = DIR_UP;
        end else if (press_q[3]) begin
            cand = DIR_DOWN;
        end else if (press_q[0]) begin
            cand = DIR_LEFT;
        end else begin
            cand = DIR_RIGHT;
        end

        // Reference is taken before this cycle's pop: a command is judged
        // against the heading it will follow, even if that is being popped now.
        last_ptr = wr_ptr_q - PW'(1);
        ref_dir  = (count_q != '0) ? mem_q[last_ptr] : dir_q;
        // Opposites differ only in bit 0 (LEFT/RIGHT, UP/DOWN).
        opp_dir  = dir_e'(ref_dir ^ 2'b01);

        pop            = upd_tick && (count_q != '0);
        full_after_pop = (count_q == DEPTH_C) && !pop;
        push           = cand_valid && (cand != ref_dir) && (cand != opp_dir)
                         && !full_after_pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dir_d    = dir_q;
        chg_d    = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = cand;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            dir_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
            chg_d    = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            press_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            // NOTE: the queue storage is reset as well; it is only a few bits
            // wide and this keeps the reference heading free of X after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= DIR_LEFT;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dir_q    <= DIR_RIGHT;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            chg_q    <= chg_d;
        end
    end

    assign direction   = dir_q;
    assign dir_changed = chg_q;
    assign q_count     = count_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_dir_cmd_queue
//
// Directed bench for dir_cmd_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=2.
// Inputs change 1 time unit after a rising edge; outputs are compared at the
// same point, so every check sees the state left by the preceding edge.
// A stable press becomes visible in q_count 2 + 4 + 1 = 7 edges after it is
// applied.
// -----------------------------------------------------------------------------
module tb_dir_cmd_queue;

    localparam logic [3:0] B_LEFT  = 4'b0001;
    localparam logic [3:0] B_RIGHT = 4'b0010;
    localparam logic [3:0] B_UP    = 4'b0100;
    localparam logic [3:0] B_DOWN  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       left, right, up, down;
    logic       upd_tick;
    logic [1:0] direction;
    logic       dir_changed;
    logic [1:0] q_count;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;
    int p0;

    dir_cmd_queue #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left       (left),
        .right      (right),
        .up         (up),
        .down       (down),
        .upd_tick   (upd_tick),
        .direction  (direction),
        .dir_changed(dir_changed),
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    // Counts dir_changed pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (dir_changed === 1'b1) pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        {down, up, right, left} = m;
    endtask

    // Hold long enough to debounce and queue, then release and let it settle.
    task automatic press(input logic [3:0] m);
        set_btn(m);
        step(8);
        set_btn(4'b0000);
        step(8);
    endtask

    task automatic tick();
        upd_tick = 1'b1;
        step(1);
        upd_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_btn(4'b0000);
        upd_tick = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // ---- 1: reset with UP held, then re-debounce latency ----
        rst = 1'b1;
        upd_tick = 1'b0;
        set_btn(B_UP);
        step(3);
        check("rst_direction", 32'(direction), 32'h1);
        check("rst_q_count", 32'(q_count), 32'h0);
        check("rst_dir_changed", 32'(dir_changed), 32'h0);
        rst = 1'b0;
        step(6);
        check("lat_not_yet", 32'(q_count), 32'h0);
        step(1);
        check("lat_queued", 32'(q_count), 32'h1);
        set_btn(4'b0000);
        step(8);
        tick();
        check("t1_pop_dir", 32'(direction), 32'h2);
        check("t1_pop_pulse", 32'(dir_changed), 32'h1);

        // ---- 2: bounce rejected, then a clean hold gives exactly one entry ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            down = ~down;
            step(2);
        end
        down = 1'b0;
        step(8);
        check("bounce_q_count", 32'(q_count), 32'h0);
        down = 1'b1;
        step(10);
        check("hold_q_count", 32'(q_count), 32'h1);
        down = 1'b0;
        step(10);
        check("hold_once", 32'(q_count), 32'h1);
        tick();
        check("hold_pop_dir", 32'(direction), 32'h3);

        // ---- 3: reversal / duplicate filtering ----
        do_reset();
        press(B_LEFT);
        check("reverse_dropped", 32'(q_count), 32'h0);
        press(B_RIGHT);
        check("dup_dropped", 32'(q_count), 32'h0);
        press(B_UP);
        check("up_queued", 32'(q_count), 32'h1);
        p0 = pulses;
        tick();
        check("t3_dir_up", 32'(direction), 32'h2);
        check("t3_pulse_hi", 32'(dir_changed), 32'h1);
        step(1);
        check("t3_pulse_lo", 32'(dir_changed), 32'h0);
        step(2);
        check("t3_one_pulse", 32'(pulses - p0), 32'h1);

        // ---- 4: chained turns, then tick on an empty queue ----
        do_reset();
        press(B_UP);
        press(B_LEFT);
        check("chain_q2", 32'(q_count), 32'h2);
        p0 = pulses;
        tick();
        check("chain_dir_up", 32'(direction), 32'h2);
        check("chain_q1", 32'(q_count), 32'h1);
        step(2);
        tick();
        check("chain_dir_left", 32'(direction), 32'h0);
        check("chain_q0", 32'(q_count), 32'h0);
        step(2);
        tick();
        check("empty_tick_dir", 32'(direction), 32'h0);
        check("empty_tick_pulse", 32'(dir_changed), 32'h0);
        check("empty_tick_q", 32'(q_count), 32'h0);
        step(2);
        check("chain_two_pulses", 32'(pulses - p0), 32'h2);

        // ---- 5: full queue drop, simultaneous push + pop ----
        do_reset();
        press(B_UP);
        press(B_LEFT);
        press(B_DOWN);
        check("full_drop_q", 32'(q_count), 32'h2);
        check("full_drop_dir", 32'(direction), 32'h1);
        set_btn(B_DOWN);
        step(6);
        upd_tick = 1'b1;
        step(1);
        upd_tick = 1'b0;
        check("pushpop_q", 32'(q_count), 32'h2);
        check("pushpop_dir", 32'(direction), 32'h2);
        set_btn(4'b0000);
        step(8);
        tick();
        check("pushpop_next_left", 32'(direction), 32'h0);
        step(1);
        tick();
        check("pushpop_then_down", 32'(direction), 32'h3);
        check("pushpop_drained", 32'(q_count), 32'h0);

        // ---- reset with a full queue and a press mid-debounce ----
        do_reset();
        press(B_UP);
        press(B_LEFT);
        set_btn(B_DOWN);
        step(3);
        rst = 1'b1;
        step(2);
        check("midrst_q", 32'(q_count), 32'h0);
        check("midrst_dir", 32'(direction), 32'h1);
        rst = 1'b0;
        step(6);
        check("midrst_redebounce", 32'(q_count), 32'h0);
        step(1);
        check("midrst_queued", 32'(q_count), 32'h1);
        set_btn(4'b0000);
        step(8);

        // ---- 6: priority, UP beats LEFT in the same cycle ----
        do_reset();
        press(B_UP | B_LEFT);
        check("prio_q1", 32'(q_count), 32'h1);
        tick();
        check("prio_dir_up", 32'(direction), 32'h2);
        check("prio_left_gone", 32'(q_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
